// File: rtl/flit_pkt_pkg.sv
// Shared flit packet definitions for the tx packetizer and rx counter.
// Widths, tx state encoding and header field offsets.
package flit_pkt_pkg;

   localparam int ADD_WIDTH_DEF  = 8;
   localparam int FLIT_WIDTH_DEF = 16;

   // Header layout: dest in the low field, length directly above it.
   localparam int DEST_LSB = 0;
   localparam int LEN_LSB  = DEST_LSB + ADD_WIDTH_DEF;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      HEADER   = 2'd1,
      PAYLOAD  = 2'd2,
      CHECKSUM = 2'd3
   } tx_state_e;

   // Offset of the length field for a given address width.
   function automatic int len_lsb(input int add_width);
      return DEST_LSB + add_width;
   endfunction

endpackage

// File: rtl/flit_packet_tx_if.sv
// Request / payload / flit handshake bundle of the packet transmitter.
// slave is the packetizer view, master is the surrounding logic.
interface flit_packet_tx_if
   import flit_pkt_pkg::*;
#(
   parameter int ADD_WIDTH  = ADD_WIDTH_DEF,
   parameter int FLIT_WIDTH = FLIT_WIDTH_DEF
);

   logic                  req_valid_i;
   logic                  req_ready_o;
   logic [ADD_WIDTH-1:0]  dest_i;
   logic [ADD_WIDTH-1:0]  length_i;
   logic                  data_valid_i;
   logic                  data_ready_o;
   logic [FLIT_WIDTH-1:0] data_i;
   logic                  flit_valid_o;
   logic                  flit_ready_i;
   logic [FLIT_WIDTH-1:0] flit_o;
   logic                  is_header_o;
   logic                  busy_o;

   modport slave (
      input  req_valid_i, dest_i, length_i,
      input  data_valid_i, data_i, flit_ready_i,
      output req_ready_o, data_ready_o,
      output flit_valid_o, flit_o, is_header_o, busy_o
   );

   modport master (
      output req_valid_i, dest_i, length_i,
      output data_valid_i, data_i, flit_ready_i,
      input  req_ready_o, data_ready_o,
      input  flit_valid_o, flit_o, is_header_o, busy_o
   );

endinterface

// File: rtl/flit_tx_counter.sv
// Loadable down-counter tracking payload flits left in a packet.
// Saturates at zero; last flags count==1, zero flags count==0.
module flit_tx_counter
   import flit_pkt_pkg::*;
#(
   parameter int W = ADD_WIDTH_DEF
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_i,
   input  logic         dec_i,
   input  logic [W-1:0] load_val_i,
   output logic         last_o,
   output logic         zero_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next count: load wins over decrement, never wraps below zero.
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign last_o = (count_q == W'(1));
   assign zero_o = (count_q == '0);

endmodule

// File: rtl/flit_packet_tx.sv
// Injection-port packetizer: header flit then exactly length payload flits.
// Define FLIT_TX_CHECKSUM_EN to append an XOR checksum flit per packet.
module flit_packet_tx
   import flit_pkt_pkg::*;
#(
   parameter int ADD_WIDTH  = ADD_WIDTH_DEF,
   parameter int FLIT_WIDTH = FLIT_WIDTH_DEF
) (
   input logic             clk,
   input logic             reset,
   flit_packet_tx_if.slave bus
);

   localparam int LEN_OFS = len_lsb(ADD_WIDTH);

   if (FLIT_WIDTH < 2 * ADD_WIDTH) begin : g_width_check
      $error("flit_packet_tx: FLIT_WIDTH must be >= 2*ADD_WIDTH");
   end

`ifdef FLIT_TX_CHECKSUM_EN
   localparam tx_state_e DONE_ST = CHECKSUM;
`else
   localparam tx_state_e DONE_ST = IDLE;
`endif

   tx_state_e             state_q, state_d;
   logic [ADD_WIDTH-1:0]  dest_q, dest_d;
   logic [ADD_WIDTH-1:0]  len_q, len_d;
   logic [ADD_WIDTH-1:0]  len_field;
   logic [FLIT_WIDTH-1:0] hdr_flit;

   logic                  req_ready;
   logic                  data_ready;
   logic                  flit_valid;
   logic [FLIT_WIDTH-1:0] flit;
   logic                  is_header;
   logic                  hdr_xfer;
   logic                  pay_xfer;
   logic                  cnt_load;
   logic                  cnt_last;
   logic                  cnt_zero;

`ifdef FLIT_TX_CHECKSUM_EN
   logic [FLIT_WIDTH-1:0] csum_q, csum_d;

   // The advertised count also covers the trailing checksum flit.
   assign len_field = len_q + 1'b1;
`else
   assign len_field = len_q;
`endif

   // Header flit: zero pad, length field, destination field.
   always_comb begin
      hdr_flit = '0;
      hdr_flit[DEST_LSB +: ADD_WIDTH] = dest_q;
      hdr_flit[LEN_OFS +: ADD_WIDTH]  = len_field;
   end

   assign cnt_load = hdr_xfer & (len_q != '0);

   flit_tx_counter #(
      .W          (ADD_WIDTH)
   ) u_cnt (
      .clk        (clk),
      .reset      (reset),
      .load_i     (cnt_load),
      .dec_i      (pay_xfer),
      .load_val_i (len_q),
      .last_o     (cnt_last),
      .zero_o     (cnt_zero)
   );

   // Next state, request capture and handshake outputs.
   always_comb begin
      state_d    = state_q;
      dest_d     = dest_q;
      len_d      = len_q;
      req_ready  = 1'b0;
      data_ready = 1'b0;
      flit_valid = 1'b0;
      flit       = '0;
      is_header  = 1'b0;
      hdr_xfer   = 1'b0;
      pay_xfer   = 1'b0;
      unique case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (bus.req_valid_i) begin
               dest_d  = bus.dest_i;
               len_d   = bus.length_i;
               state_d = HEADER;
            end
         end
         HEADER: begin
            flit_valid = 1'b1;
            is_header  = 1'b1;
            flit       = hdr_flit;
            if (bus.flit_ready_i) begin
               hdr_xfer = 1'b1;
               if (len_q == '0) begin
                  state_d = DONE_ST;
               end else begin
                  state_d = PAYLOAD;
               end
            end
         end
         PAYLOAD: begin
            flit_valid = bus.data_valid_i;
            data_ready = bus.flit_ready_i;
            flit       = bus.data_i;
            // An empty counter here means the packet already closed.
            if (cnt_zero) begin
               state_d = IDLE;
            end else if (bus.data_valid_i && bus.flit_ready_i) begin
               pay_xfer = 1'b1;
               if (cnt_last) begin
                  state_d = DONE_ST;
               end
            end
         end
`ifdef FLIT_TX_CHECKSUM_EN
         CHECKSUM: begin
            flit_valid = 1'b1;
            flit       = csum_q;
            if (bus.flit_ready_i) begin
               state_d = IDLE;
            end
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and captured request registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         dest_q  <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         dest_q  <= dest_d;
         len_q   <= len_d;
      end
   end

`ifdef FLIT_TX_CHECKSUM_EN
   // XOR of payload flits, restarted when the header leaves.
   always_comb begin
      csum_d = csum_q;
      if (hdr_xfer) begin
         csum_d = '0;
      end else if (pay_xfer) begin
         csum_d = csum_q ^ bus.data_i;
      end
   end

   // Checksum accumulator register.
   always_ff @(posedge clk) begin
      if (reset) begin
         csum_q <= '0;
      end else begin
         csum_q <= csum_d;
      end
   end
`endif

   assign bus.req_ready_o  = req_ready & ~reset;
   assign bus.data_ready_o = data_ready & ~reset;
   assign bus.flit_valid_o = flit_valid & ~reset;
   assign bus.is_header_o  = is_header & ~reset;
   assign bus.flit_o       = reset ? '0 : flit;
   assign bus.busy_o       = (state_q != IDLE) & ~reset;

endmodule

// File: tb/tb_flit_packet_tx.sv
// Randomized bench for flit_packet_tx against a flit-stream model.
// Build with FLIT_TX_CHECKSUM_EN to cover the checksum variant.
module tb_flit_packet_tx;

   localparam int AW = 8;
   localparam int FW = 16;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   flit_packet_tx_if #(.ADD_WIDTH(AW), .FLIT_WIDTH(FW)) bus ();

   flit_packet_tx #(
      .ADD_WIDTH (AW),
      .FLIT_WIDTH(FW)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

`ifdef FLIT_TX_CHECKSUM_EN
   always @(posedge clk) begin
      if (!reset && bus.req_valid_i)
         assert (bus.length_i != 8'hFF)
            else $error("FAIL src_len got %0h want <ff", bus.length_i);
   end
`endif

   logic [FW-1:0] pay_q[$];
   logic [FW-1:0] src_q[$];
   logic [FW-1:0] exp_q[$];
   logic [FW-1:0] obs_q[$];
   bit            hdr_q[$];
   int            xfer_cyc[$];
   int            req_cyc, hdr_cyc, consumed;
   int            stall_viol, mirror_viol;
   bit            timeout, dr_seen;

   // Expected outgoing flits: header, payload words, optional checksum.
   function automatic void build_exp(input logic [AW-1:0] d,
                                     input logic [AW-1:0] l);
      logic [AW-1:0] f;
      logic [FW-1:0] x;
      f = l;
`ifdef FLIT_TX_CHECKSUM_EN
      f = l + 1'b1;
`endif
      exp_q.delete();
      exp_q.push_back({{(FW-2*AW){1'b0}}, f, d});
      x = '0;
      foreach (pay_q[i]) begin
         exp_q.push_back(pay_q[i]);
         x = x ^ pay_q[i];
      end
`ifdef FLIT_TX_CHECKSUM_EN
      exp_q.push_back(x);
`endif
   endfunction

   task automatic fill_random(input int n);
      pay_q.delete();
      repeat (n) pay_q.push_back(FW'($urandom));
   endtask

   task automatic drive_idle();
      bus.req_valid_i  = 1'b0;
      bus.dest_i       = '0;
      bus.length_i     = '0;
      bus.data_valid_i = 1'b0;
      bus.data_i       = '0;
      bus.flit_ready_i = 1'b0;
   endtask

   // Drives one packet with random stalls and records what comes out.
   task automatic run_packet(input logic [AW-1:0] d, input logic [AW-1:0] l,
                             input int rdy_pct, input int val_pct);
      bit            req_done, dv, prev_stall;
      logic [FW-1:0] prev_flit;
      int            n;
      build_exp(d, l);
      n = exp_q.size();
      src_q = pay_q;
      obs_q.delete(); hdr_q.delete(); xfer_cyc.delete();
      req_done = 0; dv = 0; prev_stall = 0; prev_flit = '0;
      req_cyc = -1; hdr_cyc = -1; consumed = 0;
      stall_viol = 0; mirror_viol = 0; timeout = 0; dr_seen = 0;
      for (int c = 0; c < 4000 && obs_q.size() < n; c++) begin
         @(posedge clk); #1;
         bus.req_valid_i = !req_done;
         bus.dest_i      = d;
         bus.length_i    = l;
         if (src_q.size() > 0) begin
            bus.data_i = src_q[0];
            if (!dv) dv = (int'($urandom_range(99)) < val_pct);
         end else begin
            dv = 0;
            bus.data_i = FW'($urandom);
         end
         bus.data_valid_i = dv;
         bus.flit_ready_i = (int'($urandom_range(99)) < rdy_pct);
         #1;
         if (prev_stall && (bus.flit_valid_o !== 1'b1 || bus.flit_o !== prev_flit))
            stall_viol++;
         prev_stall = bus.flit_valid_o && !bus.flit_ready_i;
         prev_flit  = bus.flit_o;
         if (bus.data_ready_o) begin
            dr_seen = 1;
            if (bus.flit_valid_o !== dv || bus.is_header_o !== 1'b0 ||
                (dv && bus.flit_o !== bus.data_i))
               mirror_viol++;
         end
         if (!req_done && bus.req_ready_o) begin
            req_done = 1;
            req_cyc = cyc;
         end
         if (bus.flit_valid_o && bus.is_header_o && hdr_cyc < 0) hdr_cyc = cyc;
         if (bus.flit_valid_o && bus.flit_ready_i) begin
            obs_q.push_back(bus.flit_o);
            hdr_q.push_back(bus.is_header_o);
            xfer_cyc.push_back(cyc);
         end
         if (dv && bus.data_ready_o) begin
            void'(src_q.pop_front());
            consumed++;
            dv = 0;
         end
      end
      if (obs_q.size() < n) timeout = 1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive_idle();
      bus.req_valid_i  = 1'b1;
      bus.data_valid_i = 1'b1;
      bus.flit_ready_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({bus.req_ready_o, bus.flit_valid_o, bus.data_ready_o,
           bus.is_header_o, bus.busy_o} !== 5'b0) begin
         errors++;
         $display("FAIL reset_outs got %b want 00000",
                  {bus.req_ready_o, bus.flit_valid_o, bus.data_ready_o,
                   bus.is_header_o, bus.busy_o});
      end
      checks++;
      if (bus.flit_o !== '0) begin
         errors++;
         $display("FAIL reset_flit got %h want 0000", bus.flit_o);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      drive_idle();
      #1;
      checks++;
      if (bus.req_ready_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.flit_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL post_reset got rdy=%b busy=%b fv=%b want 1 0 0",
                  bus.req_ready_o, bus.busy_o, bus.flit_valid_o);
      end
   endtask

   task automatic test_header_only();
      pay_q.delete();
      run_packet(8'h3A, 8'h00, 100, 100);
      checks++;
      if (timeout !== 1'b0 || obs_q.size() !== exp_q.size()) begin
         errors++;
         $display("FAIL hdr_only_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      checks++;
      if (obs_q[0] !== exp_q[0] || hdr_q[0] !== 1'b1) begin
         errors++;
         $display("FAIL hdr_only_flit got %h/%b want %h/1", obs_q[0], hdr_q[0], exp_q[0]);
      end
      checks++;
      if (hdr_cyc - req_cyc !== 1) begin
         errors++;
         $display("FAIL hdr_only_latency got %0d want 1", hdr_cyc - req_cyc);
      end
      checks++;
      if (dr_seen !== 1'b0) begin
         errors++;
         $display("FAIL hdr_only_data_ready got %b want 0", dr_seen);
      end
   endtask

   task automatic test_nominal();
      pay_q = '{16'h1111, 16'h2222, 16'h3333};
      run_packet(8'h05, 8'd3, 100, 100);
      checks++;
      if (timeout !== 1'b0 || obs_q.size() !== exp_q.size()) begin
         errors++;
         $display("FAIL nominal_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i] || hdr_q[i] !== (i == 0) ||
             xfer_cyc[i] !== hdr_cyc + i) begin
            errors++;
            $display("FAIL nominal_flit%0d got %h hdr=%b at+%0d want %h hdr=%b at+%0d",
                     i, obs_q[i], hdr_q[i], xfer_cyc[i] - hdr_cyc, exp_q[i], i == 0, i);
         end
      end
      checks++;
      if (hdr_cyc - req_cyc !== 1) begin
         errors++;
         $display("FAIL nominal_latency got %0d want 1", hdr_cyc - req_cyc);
      end
      @(posedge clk); #1;
      drive_idle();
      #1;
      checks++;
      if (bus.req_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL nominal_req_ready got %b want 1", bus.req_ready_o);
      end
   endtask

   task automatic test_backpressure();
      for (int p = 0; p < 4; p++) begin
         pay_q = '{16'h1111, 16'h2222, 16'h3333};
         run_packet(8'h05, 8'd3, 40, 100);
         checks++;
         if (timeout !== 1'b0 || consumed !== 3 || stall_viol !== 0) begin
            errors++;
            $display("FAIL bp%0d got to=%b cons=%0d stall=%0d want 0 3 0",
                     p, timeout, consumed, stall_viol);
         end
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL bp%0d_flit%0d got %h want %h", p, i, obs_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_bubbles();
      for (int p = 0; p < 4; p++) begin
         fill_random(3);
         run_packet(8'h44, 8'd3, 100, 50);
         checks++;
         if (timeout !== 1'b0 || consumed !== 3 || mirror_viol !== 0 ||
             obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL bubbles%0d got to=%b cons=%0d mirror=%0d n=%0d want 0 3 0 %0d",
                     p, timeout, consumed, mirror_viol, obs_q.size(), exp_q.size());
         end
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL bubbles%0d_flit%0d got %h want %h", p, i, obs_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int a_last;
      fill_random(2);
      run_packet(8'h11, 8'd2, 100, 100);
      a_last = xfer_cyc[xfer_cyc.size() - 1];
      fill_random(1);
      run_packet(8'h22, 8'd1, 100, 100);
      checks++;
      if (req_cyc - a_last !== 1) begin
         errors++;
         $display("FAIL b2b_gap got %0d want 1", req_cyc - a_last);
      end
      checks++;
      if (timeout !== 1'b0 || obs_q[0] !== exp_q[0]) begin
         errors++;
         $display("FAIL b2b_hdr got %h want %h", obs_q[0], exp_q[0]);
      end
   endtask

   task automatic test_max_length();
      logic [AW-1:0] l;
`ifdef FLIT_TX_CHECKSUM_EN
      l = 8'hFE;
`else
      l = 8'hFF;
`endif
      fill_random(int'(l));
      run_packet(8'hC3, l, 100, 100);
      checks++;
      if (timeout !== 1'b0 || consumed !== int'(l) || obs_q.size() !== exp_q.size()) begin
         errors++;
         $display("FAIL maxlen got to=%b cons=%0d n=%0d want 0 %0d %0d",
                  timeout, consumed, obs_q.size(), int'(l), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL maxlen_flit%0d got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_reset_mid_packet();
      bit            req_done;
      int            np;
      logic [FW-1:0] want;
      fill_random(5);
      src_q = pay_q;
      req_done = 0;
      np = 0;
      for (int c = 0; c < 50 && np < 2; c++) begin
         @(posedge clk); #1;
         bus.req_valid_i  = !req_done;
         bus.dest_i       = 8'h10;
         bus.length_i     = 8'd5;
         bus.flit_ready_i = 1'b1;
         bus.data_valid_i = 1'b1;
         bus.data_i       = src_q[0];
         #1;
         if (bus.req_ready_o) req_done = 1;
         if (bus.data_ready_o) begin
            void'(src_q.pop_front());
            np++;
         end
      end
      @(posedge clk); #1;
      reset = 1'b1;
      bus.req_valid_i = 1'b1;
      #1;
      checks++;
      if ({bus.flit_valid_o, bus.req_ready_o, bus.data_ready_o, bus.busy_o} !== 4'b0) begin
         errors++;
         $display("FAIL rst_mid_during got %b want 0000",
                  {bus.flit_valid_o, bus.req_ready_o, bus.data_ready_o, bus.busy_o});
      end
      @(posedge clk); #1;
      reset = 1'b0;
      drive_idle();
      #1;
      checks++;
      if (bus.busy_o !== 1'b0 || bus.req_ready_o !== 1'b1 || bus.flit_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_after got busy=%b rdy=%b fv=%b want 0 1 0",
                  bus.busy_o, bus.req_ready_o, bus.flit_valid_o);
      end
      fill_random(1);
      run_packet(8'h07, 8'd1, 100, 100);
`ifdef FLIT_TX_CHECKSUM_EN
      want = 16'h0207;
`else
      want = 16'h0107;
`endif
      checks++;
      if (timeout !== 1'b0 || obs_q[0] !== want || hdr_q[0] !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_hdr got %h want %h", obs_q[0], want);
      end
      checks++;
      if (obs_q.size() !== exp_q.size() || obs_q[1] !== pay_q[0]) begin
         errors++;
         $display("FAIL rst_mid_pay got %h n=%0d want %h n=%0d",
                  obs_q[1], obs_q.size(), pay_q[0], exp_q.size());
      end
   endtask

   task automatic test_random();
      int l;
      for (int p = 0; p < 10; p++) begin
         l = int'($urandom_range(12));
         fill_random(l);
         run_packet(AW'($urandom), AW'(l), int'($urandom_range(30, 100)),
                    int'($urandom_range(30, 100)));
         checks++;
         if (timeout !== 1'b0 || stall_viol !== 0 || mirror_viol !== 0 ||
             consumed !== l || obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL rnd%0d got to=%b stall=%0d mirror=%0d cons=%0d n=%0d want 0 0 0 %0d %0d",
                     p, timeout, stall_viol, mirror_viol, consumed, obs_q.size(), l, exp_q.size());
         end
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i] || hdr_q[i] !== (i == 0)) begin
               errors++;
               $display("FAIL rnd%0d_flit%0d got %h hdr=%b want %h hdr=%b",
                        p, i, obs_q[i], hdr_q[i], exp_q[i], i == 0);
            end
         end
      end
   endtask

`ifdef FLIT_TX_CHECKSUM_EN
   task automatic test_checksum();
      pay_q = '{16'h00FF, 16'h0F0F};
      run_packet(8'h05, 8'd2, 100, 100);
      checks++;
      if (timeout !== 1'b0 || obs_q.size() !== 4) begin
         errors++;
         $display("FAIL csum_count got %0d want 4", obs_q.size());
      end
      checks++;
      if (obs_q[0] !== 16'h0305 || obs_q[1] !== 16'h00FF || obs_q[2] !== 16'h0F0F) begin
         errors++;
         $display("FAIL csum_body got %h %h %h want 0305 00ff 0f0f",
                  obs_q[0], obs_q[1], obs_q[2]);
      end
      checks++;
      if (obs_q[3] !== 16'h0FF0 || hdr_q[3] !== 1'b0) begin
         errors++;
         $display("FAIL csum_flit got %h hdr=%b want 0ff0 hdr=0", obs_q[3], hdr_q[3]);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_header_only();
      test_nominal();
      test_backpressure();
      test_bubbles();
      test_back_to_back();
      test_max_length();
      test_reset_mid_packet();
      test_random();
`ifdef FLIT_TX_CHECKSUM_EN
      test_checksum();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
